// File: rtl/ex_stage.sv
// Execute stage: single-cycle logic/shift/arith/multiply plus 16-step restoring divider.
// Latency 1 for single-cycle ops; divide occupies 18 cycles (accept, 16 RUN, DONE).
// Backpressure: stall_req holds upstream stages from accept through the last RUN step.
module ex_stage #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int OP_W   = 8,
    parameter int SEL_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [OP_W-1:0]   aluop,
    input  logic [SEL_W-1:0]  alusel,
    input  logic [DATA_W-1:0] reg1,
    input  logic [DATA_W-1:0] reg2,
    input  logic [ADDR_W-1:0] wd,
    input  logic              wreg,
    output logic              ex_wreg_f,
    output logic [DATA_W-1:0] ex_wdata_f,
    output logic [ADDR_W-1:0] ex_wd_f,
    output logic              stall_req,
    output logic              mem_wreg,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [ADDR_W-1:0] mem_wd
);
    localparam int SH_W  = $clog2(DATA_W);
    localparam int CNT_W = $clog2(DATA_W);

    localparam logic [SEL_W-1:0] SEL_LOGIC  = SEL_W'(1);
    localparam logic [SEL_W-1:0] SEL_SHIFT  = SEL_W'(2);
    localparam logic [SEL_W-1:0] SEL_ARITH  = SEL_W'(3);
    localparam logic [SEL_W-1:0] SEL_MULDIV = SEL_W'(4);

    localparam logic [3:0] MD_MUL   = 4'd0;
    localparam logic [3:0] MD_MULH  = 4'd1;
    localparam logic [3:0] MD_MULHU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_REM   = 4'd5;
    localparam logic [3:0] MD_REMU  = 4'd6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } div_state_t;

    logic [3:0]          w_sub;
    logic [SH_W-1:0]     w_shamt;
    logic [2*DATA_W-1:0] w_prod_s;
    logic [2*DATA_W-1:0] w_prod_u;
    logic                w_slt;
    logic                w_sltu;
    logic [DATA_W-1:0]   w_sra;
    logic [DATA_W-1:0]   w_alu_res;
    logic                w_alu_ok;
    logic                w_unused;

    assign w_sub   = aluop[3:0];
    assign w_shamt = reg2[SH_W-1:0];

    // Operands are widened before multiplying so the low 2*DATA_W bits are the exact product.
    assign w_prod_s = {{DATA_W{reg1[DATA_W-1]}}, reg1} * {{DATA_W{reg2[DATA_W-1]}}, reg2};
    assign w_prod_u = {{DATA_W{1'b0}}, reg1} * {{DATA_W{1'b0}}, reg2};
    assign w_slt    = $signed(reg1) < $signed(reg2);
    assign w_sltu   = reg1 < reg2;
    assign w_sra    = $signed(reg1) >>> w_shamt;
    assign w_unused = ^{aluop[OP_W-1:4], w_prod_u[DATA_W-1:0]};

    always_comb begin
        w_alu_res = '0;
        w_alu_ok  = 1'b0;
        case (alusel)
            SEL_LOGIC: begin
                w_alu_ok = 1'b1;
                case (w_sub)
                    4'd0:    w_alu_res = reg1 & reg2;
                    4'd1:    w_alu_res = reg1 | reg2;
                    4'd2:    w_alu_res = reg1 ^ reg2;
                    4'd3:    w_alu_res = ~(reg1 | reg2);
                    default: w_alu_ok = 1'b0;
                endcase
            end
            SEL_SHIFT: begin
                w_alu_ok = 1'b1;
                case (w_sub)
                    4'd0:    w_alu_res = reg1 << w_shamt;
                    4'd1:    w_alu_res = reg1 >> w_shamt;
                    4'd2:    w_alu_res = w_sra;
                    default: w_alu_ok = 1'b0;
                endcase
            end
            SEL_ARITH: begin
                w_alu_ok = 1'b1;
                case (w_sub)
                    4'd0:    w_alu_res = reg1 + reg2;
                    4'd1:    w_alu_res = reg1 - reg2;
                    4'd2:    w_alu_res = {{(DATA_W-1){1'b0}}, w_slt};
                    4'd3:    w_alu_res = {{(DATA_W-1){1'b0}}, w_sltu};
                    default: w_alu_ok = 1'b0;
                endcase
            end
            SEL_MULDIV: begin
                w_alu_ok = 1'b1;
                case (w_sub)
                    MD_MUL:   w_alu_res = w_prod_s[DATA_W-1:0];
                    MD_MULH:  w_alu_res = w_prod_s[2*DATA_W-1:DATA_W];
                    MD_MULHU: w_alu_res = w_prod_u[2*DATA_W-1:DATA_W];
                    default:  w_alu_ok = 1'b0;
                endcase
            end
            default: ;
        endcase
    end

    logic              w_is_div;
    logic              w_div_sgn;
    logic              w_div_rem;
    logic [DATA_W-1:0] w_div0_res;
    logic [DATA_W-1:0] w_abs_a;
    logic [DATA_W-1:0] w_abs_b;

    assign w_is_div   = (alusel == SEL_MULDIV) && (w_sub >= MD_DIV) && (w_sub <= MD_REMU);
    assign w_div_sgn  = (w_sub == MD_DIV) || (w_sub == MD_REM);
    assign w_div_rem  = (w_sub == MD_REM) || (w_sub == MD_REMU);
    assign w_div0_res = w_div_rem ? reg1 : '1;
    assign w_abs_a    = (w_div_sgn && reg1[DATA_W-1]) ? -reg1 : reg1;
    assign w_abs_b    = (w_div_sgn && reg2[DATA_W-1]) ? -reg2 : reg2;

    div_state_t        r_state;
    div_state_t        w_state_nx;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nx;
    logic [DATA_W-1:0] r_rem;
    logic [DATA_W-1:0] r_quo;
    logic [DATA_W-1:0] r_dvs;
    logic              r_neg_q;
    logic              r_neg_r;
    logic              r_sel_rem;
    logic [ADDR_W-1:0] r_wd;
    logic              r_wreg;

    // Partial remainder always stays below the divisor, so DATA_W+1 bits hold the shifted value.
    logic [DATA_W:0]   w_rem_sh;
    logic [DATA_W:0]   w_diff;
    logic              w_fits;
    logic [DATA_W-1:0] w_q_fix;
    logic [DATA_W-1:0] w_r_fix;
    logic [DATA_W-1:0] w_div_res;

    assign w_rem_sh  = {r_rem, r_quo[DATA_W-1]};
    assign w_diff    = w_rem_sh - {1'b0, r_dvs};
    assign w_fits    = ~w_diff[DATA_W];
    assign w_q_fix   = r_neg_q ? -r_quo : r_quo;
    assign w_r_fix   = r_neg_r ? -r_rem : r_rem;
    assign w_div_res = r_sel_rem ? w_r_fix : w_q_fix;

    logic              w_accept;
    logic              w_step;
    logic              w_stall;
    logic              w_fwd_we;
    logic [DATA_W-1:0] w_fwd_dat;
    logic [ADDR_W-1:0] w_fwd_wd;

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_accept   = 1'b0;
        w_step     = 1'b0;
        w_stall    = 1'b0;
        w_fwd_we   = 1'b0;
        w_fwd_dat  = '0;
        w_fwd_wd   = wd;
        case (r_state)
            ST_IDLE: begin
                if (!flush) begin
                    if (w_is_div && (reg2 != '0)) begin
                        w_accept   = 1'b1;
                        w_stall    = 1'b1;
                        w_cnt_nx   = '0;
                        w_state_nx = ST_RUN;
                    end else if (w_is_div) begin
                        w_fwd_we  = wreg;
                        w_fwd_dat = w_div0_res;
                    end else if (w_alu_ok) begin
                        w_fwd_we  = wreg;
                        w_fwd_dat = w_alu_res;
                    end
                end
            end
            ST_RUN: begin
                if (flush) begin
                    w_state_nx = ST_IDLE;
                    w_cnt_nx   = '0;
                end else begin
                    w_stall = 1'b1;
                    w_step  = 1'b1;
                    if (r_cnt == CNT_W'(DATA_W-1)) begin
                        w_state_nx = ST_DONE;
                        w_cnt_nx   = '0;
                    end else begin
                        w_cnt_nx = r_cnt + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                w_state_nx = ST_IDLE;
                if (!flush) begin
                    w_fwd_we  = r_wreg;
                    w_fwd_dat = w_div_res;
                    w_fwd_wd  = r_wd;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rem     <= '0;
            r_quo     <= '0;
            r_dvs     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_sel_rem <= 1'b0;
            r_wd      <= '0;
            r_wreg    <= 1'b0;
        end else if (w_accept) begin
            r_rem     <= '0;
            r_quo     <= w_abs_a;
            r_dvs     <= w_abs_b;
            r_neg_q   <= w_div_sgn && (reg1[DATA_W-1] ^ reg2[DATA_W-1]);
            r_neg_r   <= w_div_sgn && reg1[DATA_W-1];
            r_sel_rem <= w_div_rem;
            r_wd      <= wd;
            r_wreg    <= wreg;
        end else if (w_step) begin
            r_rem <= w_fits ? w_diff[DATA_W-1:0] : w_rem_sh[DATA_W-1:0];
            r_quo <= {r_quo[DATA_W-2:0], w_fits};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_wreg  <= 1'b0;
            mem_wdata <= '0;
            mem_wd    <= '0;
        end else begin
            mem_wreg  <= w_fwd_we;
            mem_wdata <= w_fwd_dat;
            mem_wd    <= w_fwd_wd;
        end
    end

    assign ex_wreg_f  = w_fwd_we;
    assign ex_wdata_f = w_fwd_dat;
    assign ex_wd_f    = w_fwd_wd;
    assign stall_req  = w_stall;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: driver queues per-cycle expectations, monitor checks them.
module tb_ex_stage;
    localparam logic [2:0] S_NOP = 3'd0, S_LOG = 3'd1, S_SH = 3'd2, S_AR = 3'd3, S_MD = 3'd4;

    typedef struct {
        bit          chk_f;
        logic        f_we;
        logic [15:0] f_dat;
        logic [3:0]  f_wd;
        bit          chk_st;
        logic        st;
        logic        m_we;
        bit          chk_md;
        logic [15:0] m_dat;
        bit          chk_mwd;
        logic [3:0]  m_wd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic [7:0]  aluop = '0;
    logic [2:0]  alusel = '0;
    logic [15:0] reg1 = '0;
    logic [15:0] reg2 = '0;
    logic [3:0]  wd = '0;
    logic        wreg = 1'b0;
    logic        ex_wreg_f;
    logic [15:0] ex_wdata_f;
    logic [3:0]  ex_wd_f;
    logic        stall_req;
    logic        mem_wreg;
    logic [15:0] mem_wdata;
    logic [3:0]  mem_wd;

    int   total = 0;
    int   bad = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    ex_stage dut (
        .clk(clk), .rst(rst), .flush(flush), .aluop(aluop), .alusel(alusel),
        .reg1(reg1), .reg2(reg2), .wd(wd), .wreg(wreg),
        .ex_wreg_f(ex_wreg_f), .ex_wdata_f(ex_wdata_f), .ex_wd_f(ex_wd_f),
        .stall_req(stall_req), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_wd(mem_wd)
    );

    function automatic exp_t e_wr(input logic [15:0] dat, input logic [3:0] d);
        exp_t e;
        e = '{chk_f: 1, f_we: 1, f_dat: dat, f_wd: d, chk_st: 1, st: 0,
              m_we: 1, chk_md: 1, m_dat: dat, chk_mwd: 1, m_wd: d};
        return e;
    endfunction

    function automatic exp_t e_bub();
        exp_t e;
        e = '{chk_f: 1, f_we: 0, f_dat: 0, f_wd: 0, chk_st: 1, st: 0,
              m_we: 0, chk_md: 1, m_dat: 0, chk_mwd: 0, m_wd: 0};
        return e;
    endfunction

    function automatic exp_t e_stall();
        exp_t e;
        e = '{chk_f: 1, f_we: 0, f_dat: 0, f_wd: 0, chk_st: 1, st: 1,
              m_we: 0, chk_md: 0, m_dat: 0, chk_mwd: 0, m_wd: 0};
        return e;
    endfunction

    function automatic exp_t e_rst();
        exp_t e;
        e = '{chk_f: 0, f_we: 0, f_dat: 0, f_wd: 0, chk_st: 0, st: 0,
              m_we: 0, chk_md: 1, m_dat: 0, chk_mwd: 1, m_wd: 0};
        return e;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    task automatic step(input logic rn, input logic fl, input logic [2:0] sel,
                        input logic [3:0] sub, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] d, input logic we, input exp_t e);
        @(negedge clk);
        rst = rn; flush = fl; alusel = sel; aluop = {4'h5, sub};
        reg1 = a; reg2 = b; wd = d; wreg = we;
        exp_q.push_back(e);
    endtask

    task automatic div_op(input logic [3:0] sub, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] d, input logic [15:0] res);
        for (int i = 0; i < 17; i++) step(1, 0, S_MD, sub, a, b, d, 1, e_stall());
        step(1, 0, S_MD, sub, a, b, d, 1, e_wr(res, d));
    endtask

    // Monitor: comb outputs checked in the cycle, mem_* checked one edge later.
    initial begin : monitor
        exp_t e;
        exp_t pend;
        bit   have = 0;
        forever begin
            @(negedge clk);
            #2;
            if (have) begin
                chk("mem_wreg", {15'd0, mem_wreg}, {15'd0, pend.m_we});
                if (pend.chk_md) chk("mem_wdata", mem_wdata, pend.m_dat);
                if (pend.chk_mwd) chk("mem_wd", {12'd0, mem_wd}, {12'd0, pend.m_wd});
                have = 0;
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.chk_st) chk("stall_req", {15'd0, stall_req}, {15'd0, e.st});
                if (e.chk_f) begin
                    chk("ex_wreg_f", {15'd0, ex_wreg_f}, {15'd0, e.f_we});
                    if (e.f_we) begin
                        chk("ex_wdata_f", ex_wdata_f, e.f_dat);
                        chk("ex_wd_f", {12'd0, ex_wd_f}, {12'd0, e.f_wd});
                    end
                end
                pend = e;
                have = 1;
            end
        end
    end

    initial begin : driver
        exp_t e;
        // reset held for two edges with a live ADD on the inputs
        step(0, 0, S_AR, 4'd0, 16'h0004, 16'h0005, 4'd1, 1, e_rst());
        step(0, 0, S_AR, 4'd0, 16'h0004, 16'h0005, 4'd1, 1, e_rst());
        step(1, 0, S_AR, 4'd0, 16'h0004, 16'h0005, 4'd1, 1, e_wr(16'h0009, 4'd1));

        step(1, 0, S_SH, 4'd2, 16'h8010, 16'h0004, 4'd2, 1, e_wr(16'hF801, 4'd2));
        step(1, 0, S_SH, 4'd1, 16'h8010, 16'h0004, 4'd2, 1, e_wr(16'h0801, 4'd2));
        step(1, 0, S_SH, 4'd0, 16'h0001, 16'h00FF, 4'd2, 1, e_wr(16'h8000, 4'd2));
        step(1, 0, S_AR, 4'd1, 16'h0000, 16'h0001, 4'd4, 1, e_wr(16'hFFFF, 4'd4));
        step(1, 0, S_AR, 4'd2, 16'hFFFF, 16'h0001, 4'd5, 1, e_wr(16'h0001, 4'd5));
        step(1, 0, S_AR, 4'd3, 16'hFFFF, 16'h0001, 4'd5, 1, e_wr(16'h0000, 4'd5));
        step(1, 0, S_LOG, 4'd0, 16'hF0F0, 16'h0FF0, 4'd6, 1, e_wr(16'h00F0, 4'd6));
        step(1, 0, S_LOG, 4'd1, 16'hF0F0, 16'h0FF0, 4'd6, 1, e_wr(16'hFFF0, 4'd6));
        step(1, 0, S_LOG, 4'd2, 16'hF0F0, 16'h0FF0, 4'd6, 1, e_wr(16'hFF00, 4'd6));
        step(1, 0, S_LOG, 4'd3, 16'hF0F0, 16'h0FF0, 4'd6, 1, e_wr(16'h000F, 4'd6));
        step(1, 0, S_MD, 4'd1, 16'hFFFE, 16'h0003, 4'd7, 1, e_wr(16'hFFFF, 4'd7));
        step(1, 0, S_MD, 4'd0, 16'hFFFE, 16'h0003, 4'd7, 1, e_wr(16'hFFFA, 4'd7));
        step(1, 0, S_MD, 4'd2, 16'hFFFF, 16'hFFFF, 4'd7, 1, e_wr(16'hFFFE, 4'd7));

        // write disabled: result still travels but with wreg=0
        e = e_wr(16'h0009, 4'd1);
        e.f_we = 0;
        e.m_we = 0;
        step(1, 0, S_AR, 4'd0, 16'h0004, 16'h0005, 4'd1, 0, e);

        step(1, 0, S_LOG, 4'd5, 16'h1234, 16'h5678, 4'd8, 1, e_bub());
        step(1, 0, S_MD, 4'd7, 16'h1234, 16'h5678, 4'd8, 1, e_bub());
        step(1, 0, S_NOP, 4'd0, 16'h1234, 16'h5678, 4'd8, 1, e_bub());
        step(1, 0, 3'd6, 4'd0, 16'h1234, 16'h5678, 4'd8, 1, e_bub());
        step(1, 1, S_AR, 4'd0, 16'h0004, 16'h0005, 4'd1, 1, e_bub());

        div_op(4'd3, 16'hFFF9, 16'h0002, 4'd3, 16'hFFFD);
        div_op(4'd5, 16'hFFF9, 16'h0002, 4'd3, 16'hFFFF);
        div_op(4'd3, 16'h8000, 16'hFFFF, 4'd9, 16'h8000);
        div_op(4'd5, 16'h8000, 16'hFFFF, 4'd9, 16'h0000);
        div_op(4'd4, 16'h0064, 16'h0007, 4'd10, 16'h000E);
        div_op(4'd6, 16'h0064, 16'h0007, 4'd10, 16'h0002);

        step(1, 0, S_MD, 4'd4, 16'h1234, 16'h0000, 4'd11, 1, e_wr(16'hFFFF, 4'd11));
        step(1, 0, S_MD, 4'd6, 16'h1234, 16'h0000, 4'd11, 1, e_wr(16'h1234, 4'd11));
        step(1, 0, S_MD, 4'd3, 16'hFFF9, 16'h0000, 4'd11, 1, e_wr(16'hFFFF, 4'd11));
        step(1, 0, S_MD, 4'd5, 16'hFFF9, 16'h0000, 4'd11, 1, e_wr(16'hFFF9, 4'd11));

        // flush at RUN count 7: accept plus counts 0..6 stall, then abort
        for (int i = 0; i < 8; i++) step(1, 0, S_MD, 4'd3, 16'hFFF9, 16'h0002, 4'd3, 1, e_stall());
        step(1, 1, S_MD, 4'd3, 16'hFFF9, 16'h0002, 4'd3, 1, e_bub());
        step(1, 0, S_AR, 4'd0, 16'h0010, 16'h0020, 4'd12, 1, e_wr(16'h0030, 4'd12));

        // flush in the DONE cycle drops the result
        for (int i = 0; i < 17; i++) step(1, 0, S_MD, 4'd4, 16'h0064, 16'h0007, 4'd3, 1, e_stall());
        step(1, 1, S_MD, 4'd4, 16'h0064, 16'h0007, 4'd3, 1, e_bub());
        step(1, 0, S_AR, 4'd0, 16'h0001, 16'h0001, 4'd13, 1, e_wr(16'h0002, 4'd13));

        // flush together with a new divide in IDLE: nothing accepted
        step(1, 1, S_MD, 4'd3, 16'hFFF9, 16'h0002, 4'd3, 1, e_bub());
        step(1, 0, S_AR, 4'd1, 16'h0005, 16'h0003, 4'd14, 1, e_wr(16'h0002, 4'd14));

        // reset mid-RUN
        for (int i = 0; i < 5; i++) step(1, 0, S_MD, 4'd3, 16'hFFF9, 16'h0002, 4'd3, 1, e_stall());
        step(0, 0, S_MD, 4'd3, 16'hFFF9, 16'h0002, 4'd3, 1, e_rst());
        step(1, 0, S_AR, 4'd0, 16'h0002, 16'h0003, 4'd5, 1, e_wr(16'h0005, 4'd5));

        @(negedge clk);
        alusel = S_NOP;
        repeat (3) @(negedge clk);
        #5;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d queued expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 16-bit in-order pipeline.
- Consumes the decoded operation from the ID/EX register: aluop, alusel, two operands, destination, write-enable.
- Computes the result and registers it into the EX/MEM boundary. Also drives the combinational EX forwarding bus back into id.
- Single-cycle ALU/shift/multiply ops; iterative 16-cycle divider that stalls upstream stages via stall_req.

Parameters:
- DATA_W, 16, operand/result width (RegBus)
- ADDR_W, 4, register address width (RegAddrBus)
- OP_W, 8, aluop width; only aluop[3:0] decoded
- SEL_W, 3, alusel width

Ports:
- clk  in  1  clock
- rst  in  1  reset
- flush  in  1  kill the in-flight op (branch/exception), from pipeline control
- aluop  in  8  subop in [3:0]
- alusel  in  3  0 NOP, 1 LOGIC, 2 SHIFT, 3 ARITH, 4 MULDIV; others treated as NOP
- reg1  in  16  operand A
- reg2  in  16  operand B / shift amount
- wd  in  4  destination register
- wreg  in  1  write enable
- ex_wreg_f  out  1  forwarding write enable to id (combinational)
- ex_wdata_f  out  16  forwarding data (combinational)
- ex_wd_f  out  4  forwarding destination (combinational)
- stall_req  out  1  hold PC/IF_ID/ID_EX this cycle (combinational)
- mem_wreg  out  1  EX/MEM register: write enable
- mem_wdata  out  16  EX/MEM register: result
- mem_wd  out  4  EX/MEM register: destination

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low. rst==0 at a rising edge forces the following:
  - mem_wreg=0, mem_wdata=0, mem_wd=0.
  - Divider to IDLE, counter=0.
  - Held while low; takes effect mid-divide as well.
- Subop decode:
  - LOGIC: 0 AND, 1 OR, 2 XOR, 3 NOR.
  - SHIFT (amount = reg2[3:0]): 0 SLL, 1 SRL, 2 SRA.
  - ARITH: 0 ADD, 1 SUB, 2 SLT (signed, result 0/1), 3 SLTU.
  - MULDIV: 0 MUL (low 16 of signed product), 1 MULH (signed high 16), 2 MULHU, 3 DIV, 4 DIVU, 5 REM, 6 REMU.
  - Any undefined subop yields result 0, write enable 0.
- Arithmetic: ADD/SUB wrap modulo 2^16, no overflow trap. Multiply is a full 32-bit product computed combinationally.
- Single-cycle ops:
  - Forwarding bus = {wreg, result, wd} in the same cycle.
  - At the rising edge, mem_* <= the same values.
  - Latency 1.
- NOP or flush: forwarding wreg=0; mem_wreg<=0 and mem_wdata<=0 at the next edge.
- Divider FSM, states IDLE, RUN, DONE:
  - IDLE plus a DIV/DIVU/REM/REMU op:
    - If reg2==0, take the divide-by-zero rule below.
    - Otherwise stall_req=1 and forwarding wreg=0 this cycle.
    - Latch |A|, |B| (unsigned ops: raw values), the result signs, the subop, wd and wreg.
    - Go to RUN with count=0; mem_wreg<=0.
  - RUN: one restoring-division step per cycle (quotient bit MSB first); stall_req=1, forwarding wreg=0. After the 16th step (count==15) go to DONE.
  - DONE: stall_req=0.
    - Result = quotient (DIV/DIVU) or remainder (REM/REMU), sign-corrected: quotient negated if the signs of A and B differ; remainder takes the sign of A.
    - Forwarding bus and mem_* carry the result using the latched wd/wreg.
    - Return to IDLE at the edge.
    - Total occupancy 18 cycles: accept, 16 RUN, DONE.
  - ID_EX is held during the stall, so the inputs remain the divide op for the whole sequence. The FSM ignores input changes after acceptance.
- Divide by zero: completes in one cycle with no stall. Quotient = 0xFFFF; remainder = A.
- Signed 0x8000 / 0xFFFF: quotient 0x8000, remainder 0 (wraps, no trap).
- flush in RUN or DONE: FSM -> IDLE, stall_req drops combinationally, mem_wreg<=0, no result written.
- flush and a new divide in the same IDLE cycle: flush wins, no accept.
- stall_req is never asserted in the DONE cycle or for non-divide ops.

Test Plan:
- Reset: rst=0 for 2 edges with alusel=3, ADD, wreg=1 -> mem_wreg=0, mem_wdata=0, mem_wd=0. rst=1, reg1=0x0004, reg2=0x0005, wd=1 -> ex_wdata_f=0x0009 same cycle; next edge mem_wdata=0x0009, mem_wd=1, mem_wreg=1.
- SHIFT SRA reg1=0x8010, reg2=0x0004 -> 0xF801. SUB 0x0000-0x0001 -> 0xFFFF. SLT 0xFFFF vs 0x0001 -> 1; SLTU -> 0.
- MULH 0xFFFE*0x0003 -> 0xFFFF; MUL -> 0xFFFA. MULHU 0xFFFF*0xFFFF -> 0xFFFE; both give mem result after 1 edge with no stall.
- DIV reg1=0xFFF9 (-7), reg2=0x0002, wd=3 -> stall_req=1 for exactly 17 cycles, ex_wreg_f=0 meanwhile. DONE: ex_wdata_f=0xFFFD, then mem_wdata=0xFFFD, mem_wd=3. REM same operands -> 0xFFFF.
- DIVU by zero reg1=0x1234 -> no stall, mem_wdata=0xFFFF next edge. REMU -> 0x1234.
- flush asserted at RUN count 7 -> stall_req=0 that cycle, mem_wreg=0, FSM IDLE. A following ADD completes normally. Reset mid-RUN gives the same abort plus mem_* cleared.
